// File: rtl/ice40_audio_fb_wgt_seq.sv
// ice40_audio_fb_wgt_seq
// Sequencer and owner of the audio filter-bank weight store. The store is a
// single-port 16-bit memory with auto-incrementing addresses and a 1-cycle
// read latency.
//   LOAD : packs the flash byte stream (low byte first) into 16-bit words
//          and writes WGT_WORDS of them.
//   RUN  : per frame, rewinds the read pointer, then issues NUM_BURST bursts
//          of BURST_LEN reads, with GAP_CYC idle cycles between bursts.
// Writes and reads never share a cycle, because the two phases are disjoint
// FSM states.
//
// Optional feature: define WGT_CKSUM_EN to add a 16-bit load checksum.
//   - Adds input i_exp_cksum and output o_cksum.
//   - A load completes only if the modulo sum of the written words matches
//     i_exp_cksum.
//
// Ports
//   clk, resetn        clock; async active-low reset
//   i_load_start       pulse: begin a weight load
//   i_byte_val/i_byte  byte stream from the flash loader
//   i_frame_start      pulse: run one frame
//   i_cons_rdy         MAC accepts a word issued this cycle
//   o_init_addr        store: clear write address
//   o_wgt_wr/o_wgt_in  store: write strobe and data
//   o_rst_addr         store: clear read address
//   o_rd               store: read strobe
//   i_weight/_val      store: read data and valid
//   o_data/_val        MAC: store read data, passed through
//   o_data_last        MAC: last word of the burst
//   o_burst_idx        MAC: current burst number
//   o_load_busy        high while loading
//   o_load_done        sticky: weights are valid
//   o_frame_done       pulse at end of frame
//   o_err              pulse on a rejected request
module ice40_audio_fb_wgt_seq #(
  parameter int BURST_LEN = 64,
  parameter int NUM_BURST = 40,
  parameter int GAP_CYC   = 4,
  parameter int WGT_WORDS = NUM_BURST * BURST_LEN
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_load_start,
  input  logic        i_byte_val,
  input  logic [7:0]  i_byte,
  input  logic        i_frame_start,
  input  logic        i_cons_rdy,
`ifdef WGT_CKSUM_EN
  input  logic [15:0] i_exp_cksum,
  output logic [15:0] o_cksum,
`endif
  output logic        o_init_addr,
  output logic        o_wgt_wr,
  output logic [15:0] o_wgt_in,
  output logic        o_rst_addr,
  output logic        o_rd,
  input  logic [15:0] i_weight,
  input  logic        i_weight_val,
  output logic [15:0] o_data,
  output logic        o_data_val,
  output logic        o_data_last,
  output logic [7:0]  o_burst_idx,
  output logic        o_load_busy,
  output logic        o_load_done,
  output logic        o_frame_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_RST, S_RUN_RD, S_RUN_GAP, S_RUN_TAIL
  } state_t;

  state_t      state;
  logic        byte_ph;    // 1: low byte held, waiting for the high byte
  logic [7:0]  byte0;
  logic [14:0] wr_cnt;
  logic [8:0]  rd_cnt;
  logic [7:0]  burst_idx;
  logic [3:0]  gap_cnt;
  logic        last_q;
  logic [7:0]  idx_q;
  logic [15:0] word;
  logic        burst_end;
  logic        req;
  logic        load_ok;

  assign word      = {i_byte, byte0};
  assign burst_end = (rd_cnt == 9'(BURST_LEN - 1));
  assign req       = i_load_start | i_frame_start;

  // A read is issued only when the MAC can take it. There is no output-side
  // stall, so the issue itself is the handshake.
  assign o_rd = (state == S_RUN_RD) && i_cons_rdy;

  assign o_data      = i_weight;
  assign o_data_val  = i_weight_val;
  assign o_data_last = last_q;
  assign o_burst_idx = idx_q;

`ifdef WGT_CKSUM_EN
  logic [15:0] sum;
  assign o_cksum = sum;
  // The final word is still in flight, so fold it into the comparison.
  assign load_ok = ((sum + word) == i_exp_cksum);
`else
  assign load_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      byte_ph      <= 1'b0;
      byte0        <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      burst_idx    <= '0;
      gap_cnt      <= '0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      o_init_addr  <= 1'b0;
      o_wgt_wr     <= 1'b0;
      o_wgt_in     <= '0;
      o_rst_addr   <= 1'b0;
      o_load_busy  <= 1'b0;
      o_load_done  <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
`ifdef WGT_CKSUM_EN
      sum          <= '0;
`endif
    end else begin
      o_init_addr  <= 1'b0;
      o_wgt_wr     <= 1'b0;
      o_rst_addr   <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      // Issue-time tags, delayed one cycle to line up with the store's data.
      last_q <= o_rd && burst_end;
      idx_q  <= o_rd ? burst_idx : 8'd0;

      case (state)
        S_IDLE: begin
          if (i_load_start) begin
            state       <= S_LOAD;
            o_init_addr <= 1'b1;
            o_load_done <= 1'b0;
            o_load_busy <= 1'b1;
            byte_ph     <= 1'b0;
            wr_cnt      <= '0;
            o_err       <= i_frame_start;  // dropped frame request
`ifdef WGT_CKSUM_EN
            sum         <= '0;
`endif
          end else if (i_frame_start) begin
            if (o_load_done) begin
              state      <= S_RUN_RST;
              o_rst_addr <= 1'b1;
              rd_cnt     <= '0;
              burst_idx  <= '0;
              gap_cnt    <= '0;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          o_err <= req;
          if (i_byte_val) begin
            if (!byte_ph) begin
              byte0   <= i_byte;
              byte_ph <= 1'b1;
            end else begin
              byte_ph  <= 1'b0;
              o_wgt_wr <= 1'b1;
              o_wgt_in <= word;
              wr_cnt   <= wr_cnt + 15'd1;
`ifdef WGT_CKSUM_EN
              sum      <= sum + word;
`endif
              if (wr_cnt == 15'(WGT_WORDS - 1)) begin
                state       <= S_IDLE;
                o_load_busy <= 1'b0;
                if (load_ok) o_load_done <= 1'b1;
                else         o_err       <= 1'b1;
              end
            end
          end
        end

        S_RUN_RST: begin
          o_err <= req;
          state <= S_RUN_RD;
        end

        S_RUN_RD: begin
          o_err <= req;
          if (o_rd) begin
            if (burst_end) begin
              rd_cnt <= '0;
              if (burst_idx < 8'(NUM_BURST - 1)) begin
                if (GAP_CYC == 0) begin
                  burst_idx <= burst_idx + 8'd1;
                end else begin
                  state   <= S_RUN_GAP;
                  gap_cnt <= '0;
                end
              end else begin
                state <= S_RUN_TAIL;
              end
            end else begin
              rd_cnt <= rd_cnt + 9'd1;
            end
          end
        end

        S_RUN_GAP: begin
          o_err <= req;
          if (gap_cnt == 4'(GAP_CYC - 1)) begin
            gap_cnt   <= '0;
            burst_idx <= burst_idx + 8'd1;
            state     <= S_RUN_RD;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        // The last read's data is on the bus this cycle; done follows it.
        S_RUN_TAIL: begin
          o_err        <= req;
          o_frame_done <= 1'b1;
          burst_idx    <= '0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ice40_audio_fb_wgt_seq.sv
module tb_ice40_audio_fb_wgt_seq;
  localparam int BL = 4, NB = 2, GC = 2, WW = 8;

  logic clk = 1'b0, resetn = 1'b0;
  logic i_load_start = 0, i_byte_val = 0, i_frame_start = 0, i_cons_rdy = 0;
  logic [7:0] i_byte = '0;
  logic o_init_addr, o_wgt_wr, o_rst_addr, o_rd, o_data_val, o_data_last;
  logic o_load_busy, o_load_done, o_frame_done, o_err;
  logic [15:0] o_wgt_in, o_data, i_weight;
  logic i_weight_val;
  logic [7:0] o_burst_idx;
`ifdef WGT_CKSUM_EN
  logic [15:0] i_exp_cksum = '0;
  logic [15:0] o_cksum;
`endif

  ice40_audio_fb_wgt_seq #(.BURST_LEN(BL), .NUM_BURST(NB), .GAP_CYC(GC), .WGT_WORDS(WW)) dut (
    .clk(clk), .resetn(resetn), .i_load_start(i_load_start), .i_byte_val(i_byte_val),
    .i_byte(i_byte), .i_frame_start(i_frame_start), .i_cons_rdy(i_cons_rdy),
`ifdef WGT_CKSUM_EN
    .i_exp_cksum(i_exp_cksum), .o_cksum(o_cksum),
`endif
    .o_init_addr(o_init_addr), .o_wgt_wr(o_wgt_wr), .o_wgt_in(o_wgt_in),
    .o_rst_addr(o_rst_addr), .o_rd(o_rd), .i_weight(i_weight), .i_weight_val(i_weight_val),
    .o_data(o_data), .o_data_val(o_data_val), .o_data_last(o_data_last),
    .o_burst_idx(o_burst_idx), .o_load_busy(o_load_busy), .o_load_done(o_load_done),
    .o_frame_done(o_frame_done), .o_err(o_err));

  always #5 clk = ~clk;

  // Weight store model: auto-incrementing addresses, 1-cycle read latency.
  logic [15:0] mem [0:15];
  logic [3:0]  wa, ra;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wa <= '0; ra <= '0; i_weight <= '0; i_weight_val <= 1'b0;
    end else begin
      if (o_init_addr) wa <= '0;
      else if (o_wgt_wr) begin mem[wa] <= o_wgt_in; wa <= wa + 4'd1; end
      if (o_rst_addr) ra <= '0;
      else if (o_rd) ra <= ra + 4'd1;
      i_weight_val <= o_rd;
      if (o_rd) i_weight <= mem[ra];
    end
  end

  typedef struct packed { logic [15:0] d; logic l; logic [7:0] i; } rd_t;
  rd_t         rdq[$];
  logic [15:0] wrq[$];
  int checks = 0, errors = 0;
  int n_init, n_wr, n_rst, n_rd, n_err, n_fd, n_val, rd_bad, cyc_n = 0, t0 = 0;
  logic [31:0] rd_tr, rst_tr, fd_tr, val_tr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_init = 0; n_wr = 0; n_rst = 0; n_rd = 0; n_err = 0; n_fd = 0; n_val = 0; rd_bad = 0;
    rd_tr = '0; rst_tr = '0; fd_tr = '0; val_tr = '0;
  endtask

  // One clock cycle: settle inputs, observe/score outputs, advance past the edge.
  task automatic cyc();
    int rel;
    rd_t e;
    #1;
    rel = cyc_n - t0;
    if (o_wgt_wr) begin
      n_wr++;
      checks++;
      assert (wrq.size() > 0) else begin errors++; $error("FAIL wr_extra got=%0h exp=none", o_wgt_in); end
      if (wrq.size() > 0) chk("wr_data", 64'(o_wgt_in), 64'(wrq.pop_front()));
    end
    if (o_data_val) begin
      n_val++;
      checks++;
      assert (rdq.size() > 0) else begin errors++; $error("FAIL rd_extra got=%0h exp=none", o_data); end
      if (rdq.size() > 0) begin
        e = rdq.pop_front();
        chk("rd_data", 64'(o_data), 64'(e.d));
        chk("rd_last", 64'(o_data_last), 64'(e.l));
        chk("rd_idx", 64'(o_burst_idx), 64'(e.i));
      end
    end
    if (o_rd && (!i_cons_rdy || o_wgt_wr)) rd_bad++;
    if (o_init_addr) n_init++;
    if (o_rst_addr) n_rst++;
    if (o_rd) n_rd++;
    if (o_err) n_err++;
    if (o_frame_done) n_fd++;
    if (rel >= 0 && rel < 32) begin
      rd_tr[rel] = o_rd; rst_tr[rel] = o_rst_addr; fd_tr[rel] = o_frame_done; val_tr[rel] = o_data_val;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  function automatic logic [63:0] outs();
    return 64'({o_init_addr, o_wgt_wr, o_wgt_in, o_rst_addr, o_rd, o_data_last, o_burst_idx,
                o_load_busy, o_load_done, o_frame_done, o_err});
  endfunction

  // Load nbytes of 0,1,2,...; bad offsets the expected checksum when enabled.
  task automatic do_load(input int nbytes, input int bad);
    logic [15:0] s;
    s = '0;
    for (int k = 1; k < 2*WW; k += 2) s = s + {8'(k), 8'(k-1)};
`ifdef WGT_CKSUM_EN
    i_exp_cksum = s + 16'(bad);
`else
    if (bad != 0) s = s + 16'(bad);
`endif
    i_load_start = 1; cyc();
    i_load_start = 0; i_frame_start = 0;
    for (int k = 0; k < nbytes; k++) begin
      i_byte_val = 1; i_byte = 8'(k);
      if (k < 2*WW && (k % 2) == 1) wrq.push_back({8'(k), 8'(k-1)});
      cyc();
    end
    i_byte_val = 0;
    cyc(); cyc();
  endtask

  // pat 0: always ready (timing traces checked); pat 1: ready every 3rd cycle.
  task automatic run_frame(input int pat, input bit mid_req);
    clr();
    for (int k = 0; k < BL*NB; k++) rdq.push_back({{8'(2*k+1), 8'(2*k)}, (k % BL) == BL-1, 8'(k / BL)});
    t0 = cyc_n;
    i_frame_start = 1; i_cons_rdy = (pat == 0); cyc();
    for (int i = 0; i < 200 && n_fd == 0; i++) begin
      i_frame_start = mid_req && (cyc_n - t0 == 4);
      i_cons_rdy = (pat == 0) || ((cyc_n - t0) % 3 == 0);
      cyc();
    end
    i_frame_start = 0; i_cons_rdy = 0;
    cyc(); cyc();
    chk("frame_done_cnt", 64'(n_fd), 64'd1);
    chk("rd_cnt", 64'(n_rd), 64'(BL*NB));
    chk("val_cnt", 64'(n_val), 64'(BL*NB));
    chk("rd_gate", 64'(rd_bad), 64'd0);
    chk("rdq_empty", 64'(rdq.size()), 64'd0);
    chk("mid_err", 64'(n_err), 64'(mid_req));
    if (pat == 0) begin
      chk("rst_trace", 64'(rst_tr), 64'h2);
      chk("rd_trace", 64'(rd_tr), 64'hF3C);
      chk("val_trace", 64'(val_tr), 64'h1E78);
      chk("fd_trace", 64'(fd_tr), 64'h2000);
    end
  endtask

  initial begin
    cyc(); cyc();
    chk("reset_outs", outs(), 64'd0);
    resetn = 1; cyc();

    // Frame before any load is rejected.
    clr();
    i_frame_start = 1; cyc(); i_frame_start = 0; cyc(); cyc();
    chk("noload_err", 64'(n_err), 64'd1);
    chk("noload_rst", 64'(n_rst), 64'd0);

    // Load with a simultaneous frame request; 17th byte must be ignored.
    clr();
    i_frame_start = 1;
    do_load(2*WW + 1, 0);
    chk("load_err", 64'(n_err), 64'd1);
    chk("load_init", 64'(n_init), 64'd1);
    chk("load_wr_cnt", 64'(n_wr), 64'(WW));
    chk("load_wrq", 64'(wrq.size()), 64'd0);
    chk("load_done", 64'(o_load_done), 64'd1);
    chk("load_busy", 64'(o_load_busy), 64'd0);

    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    run_frame(1, 1'b0);

    // Reset after the third read.
    clr();
    for (int k = 0; k < BL*NB; k++) rdq.push_back({{8'(2*k+1), 8'(2*k)}, (k % BL) == BL-1, 8'(k / BL)});
    i_cons_rdy = 1; i_frame_start = 1; cyc(); i_frame_start = 0;
    for (int i = 0; i < 20 && n_rd < 3; i++) cyc();
    chk("pre_reset_rd", 64'(n_rd), 64'd3);
    resetn = 0; i_cons_rdy = 0; #1;
    chk("midrun_reset_outs", outs(), 64'd0);
    rdq.delete();
    cyc(); resetn = 1; cyc();
    clr();
    i_frame_start = 1; cyc(); i_frame_start = 0; cyc(); cyc();
    chk("post_reset_err", 64'(n_err), 64'd1);
    chk("post_reset_rst", 64'(n_rst), 64'd0);

`ifdef WGT_CKSUM_EN
    clr();
    do_load(2*WW, 1);
    chk("cksum_bad_err", 64'(n_err), 64'd1);
    chk("cksum_bad_done", 64'(o_load_done), 64'd0);
    clr();
    do_load(2*WW, 0);
    chk("cksum_ok_done", 64'(o_load_done), 64'd1);
    chk("cksum_ok_err", 64'(n_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ice40_audio_fb_wgt_seq.md
Name: ice40_audio_fb_wgt_seq

Overview:
- Sequencer and owner of the audio filter-bank weight store (single-port SPRAM or EBRAM, 16-bit words, auto-incrementing addresses, 1-cycle read latency).
- LOAD phase: packs a byte stream from the flash loader into 16-bit words and writes them.
- RUN phase: on each frame start, rewinds the read pointer and issues NUM_BURST bursts of BURST_LEN reads to the MAC, with GAP_CYC idle cycles between bursts.
- Guarantees that writes and reads are never issued in the same cycle.

Parameters:
BURST_LEN, 64, words per burst (filter taps); 1..256
NUM_BURST, 40, bursts per frame (filters); 1..256
GAP_CYC, 4, idle cycles between bursts; 0..15
WGT_WORDS, NUM_BURST*BURST_LEN, words accepted per load; must be <=16384

Ports:
clk  in  1  clock
resetn  in  1  async reset, active-low
i_load_start  in  1  pulse: begin weight load
i_byte_val  in  1  byte strobe
i_byte  in  8  weight byte; low byte first
i_frame_start  in  1  pulse: run one frame
i_cons_rdy  in  1  MAC can accept a word issued this cycle
o_init_addr  out  1  to store: clear write address
o_wgt_wr  out  1  to store: write strobe
o_wgt_in  out  16  to store: write data
o_rst_addr  out  1  to store: clear read address
o_rd  out  1  to store: read strobe
i_weight  in  16  from store: read data
i_weight_val  in  1  from store: read-data valid
o_data  out  16  to MAC: i_weight, passed through combinationally
o_data_val  out  1  to MAC: i_weight_val, passed through
o_data_last  out  1  aligned with o_data_val; last word of burst
o_burst_idx  out  8  aligned with o_data_val; current burst number
o_load_busy  out  1  high while in LOAD
o_load_done  out  1  sticky; weights valid
o_frame_done  out  1  1-cycle pulse at end of frame
o_err  out  1  1-cycle pulse on a rejected request

Behaviour:
- Reset: all outputs 0, state IDLE, loaded flag 0, byte-phase 0, all counters 0. Store contents are not cleared, but a reload is required after reset.
- States: IDLE, LOAD, RUN_RST, RUN_RD, RUN_GAP, RUN_TAIL.

IDLE:
- i_load_start -> o_init_addr=1 for the next cycle, o_load_done cleared, enter LOAD.
- Else i_frame_start with loaded=1 -> RUN_RST.
- i_frame_start with loaded=0 -> o_err pulse, stay in IDLE.
- load_start and frame_start in the same cycle -> load wins; o_err pulses for the dropped frame_start.

LOAD:
- First byte is latched.
- Second byte -> o_wgt_wr=1 for one cycle (registered) with o_wgt_in={byte1,byte0}; word counter increments.
- After word WGT_WORDS-1 is written -> loaded=1, o_load_done=1, return to IDLE.
- Bytes beyond the count and bytes outside LOAD are ignored.
- i_frame_start or i_load_start during LOAD -> o_err, ignored.

RUN_RST:
- o_rst_addr=1 for exactly one cycle, then RUN_RD.
- Latency: frame_start sampled at cycle T -> o_rst_addr at T+1 -> first o_rd no earlier than T+2.

RUN_RD:
- o_rd = i_cons_rdy (combinational gate on the state), so a word is issued only when the MAC is ready.
- Word counter increments on each o_rd; there is no output-side stall, and data arrives at issue+1.
- After the BURST_LEN-th o_rd:
  - burst_idx < NUM_BURST-1 -> RUN_GAP, or directly the next RUN_RD when GAP_CYC=0.
  - Otherwise -> RUN_TAIL.

RUN_GAP:
- Counts GAP_CYC cycles with o_rd=0, increments burst index, returns to RUN_RD.

RUN_TAIL:
- Waits one cycle for the last data word.
- o_frame_done pulses in the cycle after the last o_data_val; return to IDLE.

Tagging:
- o_data_last and o_burst_idx are registered copies of the issue-time flags, so they align with i_weight_val.

Exclusivity:
- o_wgt_wr and o_rd are never both 1.
- i_load_start or i_frame_start during any RUN_* state -> o_err, ignored; the frame continues.
- Async reset mid-LOAD or mid-RUN: immediate return to IDLE, loaded=0, pending tags dropped.

Optional Feature:
- Macro: WGT_CKSUM_EN.
- When defined:
  - Adds input i_exp_cksum[15:0] and output o_cksum[15:0].
  - A 16-bit modulo sum of every written word is cleared on load start.
  - At load end, o_load_done/loaded are set only if the sum equals i_exp_cksum; otherwise o_err pulses and loaded stays 0.
- When undefined: those ports and the logic are absent, and load end always sets loaded.

Test Plan:
- Directed tests use BURST_LEN=4, NUM_BURST=2, GAP_CYC=2, WGT_WORDS=8.
- Load: 16 bytes 0x00..0x0F -> o_init_addr one pulse; 8 o_wgt_wr with o_wgt_in 0x0100, 0x0302 … 0x0F0E; o_load_done=1 after the 8th write; 17th byte ignored.
- Frame, i_cons_rdy=1: o_rst_addr at T+1; o_rd high for 4 cycles, 2 cycles low, 4 cycles high; o_data_last on the 4th and 8th o_data_val; o_burst_idx 0 then 1; o_frame_done one cycle after the 8th valid.
- Backpressure: toggle i_cons_rdy 1,0,0,1… -> o_rd only in ready cycles; still exactly 8 words, same order and tags.
- Requests: frame_start before any load -> o_err, no o_rst_addr. frame_start mid-frame -> o_err, frame unchanged. Simultaneous load_start+frame_start in IDLE -> LOAD entered and o_err.
- Reset after the 3rd o_rd -> all outputs 0; next frame_start gives o_err (loaded cleared).
- WGT_CKSUM_EN: correct i_exp_cksum -> done=1; off-by-one i_exp_cksum -> o_err, done=0.
